// File: rtl/fht_ram_reader.sv
// FHT result RAM read-out engine: fetches one row (four banks) at a time and streams it
// over valid/ready. Define FHT_RD_BITREV_EN to bit-reverse row addresses (natural-order output).
module fht_ram_reader #(
    parameter int unsigned D_BIT  = 16,
    parameter int unsigned A_BIT  = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic [A_BIT-1:0] oADDR_RD,
    input  logic [D_BIT-1:0] iRAM_0,
    input  logic [D_BIT-1:0] iRAM_1,
    input  logic [D_BIT-1:0] iRAM_2,
    input  logic [D_BIT-1:0] iRAM_3,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int unsigned          LAT_W    = 2;
    localparam logic [LAT_W-1:0]     LAT_END  = LAT_W'(RD_LAT - 1);
    localparam logic [A_BIT-1:0]     LAST_ROW = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state, state_d;
    logic [A_BIT-1:0]         row, row_d;
    logic [A_BIT-1:0]         addr_d;
    logic [1:0]               widx, widx_d;
    logic [3:0][D_BIT-1:0]    row_buf, row_buf_d;
    logic [3:0][D_BIT-1:0]    pf_buf, pf_buf_d;
    logic [3:0][D_BIT-1:0]    ram;
    logic                     pf_valid, pf_valid_d;
    logic                     pend, pend_d;
    logic [LAT_W-1:0]         lat_cnt, lat_cnt_d;
    logic [D_BIT-1:0]         data_d;
    logic                     valid_d, last_d, busy_d, done_d;
    logic                     capture;
    logic                     handshake;

    assign ram       = {iRAM_3, iRAM_2, iRAM_1, iRAM_0};
    assign capture   = pend && (lat_cnt == LAT_END);
    assign handshake = oVALID && iREADY;

    // Physical RAM row for logical row r
    function automatic logic [A_BIT-1:0] addr_of(input logic [A_BIT-1:0] r);
        logic [A_BIT-1:0] a;
        a = '0;
`ifdef FHT_RD_BITREV_EN
        for (int i = 0; i < int'(A_BIT); i++) begin
            a[i] = r[int'(A_BIT) - 1 - i];
        end
`else
        a = r;
`endif
        return a;
    endfunction

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d    = state;
        row_d      = row;
        widx_d     = widx;
        row_buf_d  = row_buf;
        pf_buf_d   = pf_buf;
        pf_valid_d = pf_valid;
        pend_d     = pend;
        lat_cnt_d  = lat_cnt;
        addr_d     = oADDR_RD;

        // A single read is in flight at a time; lat_cnt counts edges since launch
        if (pend) begin
            if (capture) begin
                pend_d = 1'b0;
            end else begin
                lat_cnt_d = lat_cnt + LAT_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (iSTART) begin
                    state_d    = FETCH;
                    row_d      = '0;
                    widx_d     = '0;
                    addr_d     = addr_of('0);
                    pend_d     = 1'b1;
                    lat_cnt_d  = '0;
                    pf_valid_d = 1'b0;
                end
            end
            FETCH: begin
                if (capture) begin
                    row_buf_d = ram;
                    widx_d    = '0;
                    state_d   = SEND;
                    if (row != LAST_ROW) begin
                        addr_d    = addr_of(row + A_BIT'(1));
                        pend_d    = 1'b1;
                        lat_cnt_d = '0;
                    end
                end
            end
            SEND: begin
                if (capture) begin
                    pf_buf_d   = ram;
                    pf_valid_d = 1'b1;
                end
                if (handshake) begin
                    if (widx != 2'd3) begin
                        widx_d = widx + 2'd1;
                    end else if (row == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        row_d  = row + A_BIT'(1);
                        widx_d = '0;
                        // Zero-bubble row swap when the prefetch has landed
                        if (pf_valid || capture) begin
                            row_buf_d  = pf_valid ? pf_buf : ram;
                            pf_valid_d = 1'b0;
                            if (row_d != LAST_ROW) begin
                                addr_d    = addr_of(row_d + A_BIT'(1));
                                pend_d    = 1'b1;
                                lat_cnt_d = '0;
                            end
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == SEND);
        busy_d  = (state_d == FETCH) || (state_d == SEND);
        done_d  = (state_d == DONE);
        data_d  = valid_d ? row_buf_d[widx_d] : oDATA;
        last_d  = valid_d && (widx_d == 2'd3) && (row_d == LAST_ROW);
    end

    // State and output registers
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state    <= IDLE;
            row      <= '0;
            widx     <= '0;
            row_buf  <= '0;
            pf_buf   <= '0;
            pf_valid <= 1'b0;
            pend     <= 1'b0;
            lat_cnt  <= '0;
            oADDR_RD <= '0;
            oDATA    <= '0;
            oVALID   <= 1'b0;
            oLAST    <= 1'b0;
            oBUSY    <= 1'b0;
            oDONE    <= 1'b0;
        end else begin
            state    <= state_d;
            row      <= row_d;
            widx     <= widx_d;
            row_buf  <= row_buf_d;
            pf_buf   <= pf_buf_d;
            pf_valid <= pf_valid_d;
            pend     <= pend_d;
            lat_cnt  <= lat_cnt_d;
            oADDR_RD <= addr_d;
            oDATA    <= data_d;
            oVALID   <= valid_d;
            oLAST    <= last_d;
            oBUSY    <= busy_d;
            oDONE    <= done_d;
        end
    end

endmodule

// File: doc/fht_ram_reader.md
Name: fht_ram_reader

Overview:
- Read-out engine for the FHT result RAM; the counterpart to the external writer that loads ADC samples through iWE/iDATA/iADDR_WR.
- After the transform completes, it drives the four bank read addresses of fht_top (iADDR_RD_0..3) and captures oDATA_0..3.
- It reorders rows from bit-reversed to natural order and streams the samples out one word per beat over a valid/ready handshake.
- Sits between fht_top and any downstream consumer: IFHT reload logic, DMA, or a host interface.

Parameters:
- D_BIT, 16, sample width, equal to fht_top D_BIT
- A_BIT, 8, row address width; BANK_SIZE = 2**A_BIT rows, 4 banks, so 4*2**A_BIT samples per frame
- RD_LAT, 2, RAM read latency in clocks from address to data valid; legal range 1..3

Ports:
- iCLK  in  1  clock
- iRESET  in  1  synchronous, active-low reset
- iSTART  in  1  one-cycle pulse that starts read-out of a frame; ignored unless idle
- oADDR_RD  out  A_BIT  row address, fanned to all four iADDR_RD_n of fht_top
- iRAM_0..iRAM_3  in  D_BIT each  bank read data (fht_top oDATA_0..3)
- oDATA  out  D_BIT  output sample
- oVALID  out  1  oDATA valid
- iREADY  in  1  consumer accepts the word when oVALID & iREADY
- oLAST  out  1  high with the final word of the frame
- oBUSY  out  1  high from the iSTART acceptance cycle until the cycle after the last handshake
- oDONE  out  1  one-cycle pulse the cycle after the last word is accepted

Behaviour:
- Reset (iRESET=0 at a clock edge) returns the block to IDLE. Reset values:
  - oADDR_RD=0, oDATA=0, oVALID=0, oLAST=0, oBUSY=0, oDONE=0
  - row counter=0, word index=0, prefetch flag=0
- Reset mid-frame aborts immediately; no further words are produced.
- States:
  - IDLE: outputs quiescent. iSTART=1 -> drive oADDR_RD=ADDR(0), oBUSY=1, go to FETCH.
  - FETCH: wait RD_LAT cycles. On the final wait cycle, latch iRAM_0..3 into the row buffer; go to SEND with word index 0.
  - SEND: oVALID=1 and oDATA=buf[word index]; the index advances only on handshake.
    - Next-row prefetch: in the first SEND cycle of each row, if the current row is not the last, drive oADDR_RD=ADDR(row+1). Capture iRAM_0..3 into the prefetch buffer exactly RD_LAT cycles later, regardless of iREADY.
    - Handshake on word 3, not last row: if the prefetch is captured, swap it into the row buffer and stay in SEND (zero-bubble); otherwise go to FETCH without re-issuing the address.
    - Handshake on word 3 of row 2**A_BIT-1: go to DONE.
  - DONE: oVALID=0, oBUSY=0, oDONE=1 for one cycle, then IDLE.
- ADDR(r): bit-reverse of r over A_BIT bits when FHT_RD_BITREV_EN is defined, otherwise r.
- Output order: row0 bank0, bank1, bank2, bank3; row1 bank0, and so on. Frame length is 4*2**A_BIT words.
- oLAST=1 only while word index=3 on the last row and oVALID=1.
- Handshake rules:
  - oDATA and oLAST are stable while oVALID & ~iREADY.
  - oVALID never drops before the handshake.
- Throughput with iREADY held at 1: one word per clock after the first fetch.
  - First oVALID appears RD_LAT+1 cycles after the iSTART cycle.
  - Since RD_LAT ≤ 3, the prefetch is always ready before word 3 is accepted.
- iSTART while busy is ignored. iSTART in the DONE cycle is ignored.
- The row counter is A_BIT+? free of wrap: the block finishes at the last row and never wraps to 0 inside a frame.
- Data is passed through unmodified; there is no scaling or sign handling.

Optional Feature:
- FHT_RD_BITREV_EN defined: row addresses are bit-reversed, so FHT output stored in bit-reversed row order leaves in natural order. This is the inverse of the write-side ordering.
- FHT_RD_BITREV_EN undefined: rows are read linearly 0..2**A_BIT-1, giving a raw RAM dump. This is used for IFHT reload and debug.

Test Plan:
- A_BIT=3, bank b row r preloaded with 16*r+b, BITREV off, iREADY=1, pulse iSTART:
  - 32 words 0,1,2,3,16,17,...,115 on consecutive cycles.
  - oLAST with 115, oDONE on the next cycle.
  - First oVALID 3 cycles after iSTART (RD_LAT=2).
- Same preload, BITREV on: oADDR_RD sequence 0,4,2,6,1,5,3,7; words 0,1,2,3,64,65,66,67,32,...; last word 115.
- Backpressure: iREADY toggles 1,0,0,1 repeating:
  - Same 32 words, no duplicates or drops.
  - oDATA held stable during stalls.
  - oDONE only after the 32nd handshake.
- iSTART pulsed again at word 10 of a frame: ignored; frame completes normally, oBUSY stays 1 throughout.
- iRESET=0 asserted at word 13, then released: all outputs 0 the next cycle; a new iSTART restarts from row 0 with word 0.
- RD_LAT=3 sweep with iREADY=1: no bubble between rows, 32 consecutive valid cycles.
